// File: rtl/deserialize_if.sv
// Link and consumer-side signals of the serial receiver.
// The pin side (sda/scl) and the word handshake (data/ordy/ack) travel together.
// The status flags (overrun/busy) are carried alongside them.
interface deserialize_if #(
  parameter int WIDTH = 8
);
  logic             sda;
  logic             scl;
  logic             ack;
  logic [WIDTH-1:0] data;
  logic             ordy;
  logic             overrun;
  logic             busy;

  // Environment side: drives the link pins and the ack, observes the word.
  modport master (
    output sda, scl, ack,
    input  data, ordy, overrun, busy
  );

  // Receiver side.
  modport slave (
    input  sda, scl, ack,
    output data, ordy, overrun, busy
  );
endinterface

// File: rtl/deserialize.sv
// Receive end of the two-wire sda/scl serial link.
// scl and sda are oversampled on cin. WIDTH bits are shifted in MSB first.
// Each complete word is held on data with an ordy/ack handshake.
// A word that lands while the previous one is still unread overwrites it
// and sets the sticky overrun flag.
// A word that stalls mid-way for TIMEOUT cin cycles is silently dropped.
module deserialize #(
  parameter int SCL_MODE    = 1,   // 1: scl idles low, sample on fall; 0: idles high, sample on rise
  parameter int WIDTH       = 8,   // bits per word, >= 2
  parameter int SYNC_STAGES = 2,   // synchroniser depth, >= 2
  parameter int TIMEOUT     = 64   // cin cycles without a sampling edge before a partial word is dropped
) (
  input  logic          cin,
  input  logic          reset,
  deserialize_if.slave  link
);

  localparam int   CNT_W    = $clog2(WIDTH + 1);
  localparam int   TMO_W    = $clog2(TIMEOUT);
  localparam logic SCL_IDLE = (SCL_MODE != 0) ? 1'b0 : 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Synchroniser chains; the last stage is the usable, metastability-filtered value.
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   w_scl_s;
  logic                   w_sda_s;
  logic                   w_sample_edge;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_shift;
  logic [WIDTH-1:0]       w_shift_nxt;
  logic [WIDTH-1:0]       w_shifted;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [TMO_W-1:0]       r_tmo;
  logic [TMO_W-1:0]       w_tmo_nxt;
  logic [WIDTH-1:0]       r_data;
  logic [WIDTH-1:0]       w_data_nxt;
  logic                   r_ordy;
  logic                   w_ordy_nxt;
  logic                   r_overrun;
  logic                   w_overrun_nxt;
  logic                   w_word_done;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // The active edge is scl returning to its idle level, seen one cycle late through r_scl_d.
  assign w_sample_edge = (SCL_MODE != 0) ? (r_scl_d & ~w_scl_s) : (~r_scl_d & w_scl_s);

  // Word as it would stand after shifting in the current sda sample.
  assign w_shifted = {r_shift[WIDTH-2:0], w_sda_s};

  // Bring scl/sda into the cin domain; the chains reset to the line idle levels so no false edge follows reset.
  always_ff @(posedge cin or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= {SYNC_STAGES{SCL_IDLE}};
      r_sda_sync <= '0;
      r_scl_d    <= SCL_IDLE;
    end else begin
      // NOTE: non-blocking assignments make every stage load the previous stage's old value, forming a real chain.
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], link.scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], link.sda};
      r_scl_d    <= w_scl_s;
    end
  end

  // Next-state logic: bit shifting, word completion, stall timeout and the ordy/ack handshake.
  always_comb begin
    // NOTE: every output gets a hold value first so no path through the case leaves one unassigned (no latch).
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_data_nxt    = r_data;
    w_ordy_nxt    = r_ordy;
    w_overrun_nxt = r_overrun;
    w_word_done   = 1'b0;

    // The consumer takes the held word; a completion later in this block may set ordy again.
    if (r_ordy && link.ack) begin
      w_ordy_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_sample_edge) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = CNT_W'(1);
          w_tmo_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_sample_edge) begin
          w_shift_nxt = w_shifted;
          w_tmo_nxt   = '0;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_word_done = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          // Transmitter stalled: drop the partial word without touching data or flags.
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_word_done) begin
      w_data_nxt = w_shifted;
      w_ordy_nxt = 1'b1;
      // Only an unread word is lost; an ack on this same edge already consumed the old one.
      if (r_ordy && !link.ack) begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge cin or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_data    <= '0;
      r_ordy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_data    <= w_data_nxt;
      r_ordy    <= w_ordy_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign link.data    = r_data;
  assign link.ordy    = r_ordy;
  assign link.overrun = r_overrun;
  assign link.busy    = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_deserialize.sv
// Bench for deserialize.
// DUT A runs with SCL_MODE=1 and WIDTH=8. DUT B runs with SCL_MODE=0 and WIDTH=16.
// Expected words are queued when a full word is sent; a negedge monitor pops them when a new word appears.
module tb_deserialize;

  localparam int SYNC = 2;
  localparam int TMO  = 64;

  logic cin = 1'b0;
  always #5 cin = ~cin;

  logic [1:0] rst_n_drv = 2'b00;
  logic [1:0] scl_drv   = 2'b10;
  logic [1:0] sda_drv   = 2'b00;
  logic [1:0] ack_drv   = 2'b00;

  deserialize_if #(.WIDTH(8))  if_a ();
  deserialize_if #(.WIDTH(16)) if_b ();

  assign if_a.scl = scl_drv[0];
  assign if_a.sda = sda_drv[0];
  assign if_a.ack = ack_drv[0];
  assign if_b.scl = scl_drv[1];
  assign if_b.sda = sda_drv[1];
  assign if_b.ack = ack_drv[1];

  deserialize #(.SCL_MODE(1), .WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) u_dut_a (
    .cin   (cin),
    .reset (rst_n_drv[0]),
    .link  (if_a)
  );

  deserialize #(.SCL_MODE(0), .WIDTH(16), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) u_dut_b (
    .cin   (cin),
    .reset (rst_n_drv[1]),
    .link  (if_b)
  );

  logic [1:0] o_ordy, o_busy, o_ovr;
  assign o_ordy = {if_b.ordy, if_a.ordy};
  assign o_busy = {if_b.busy, if_a.busy};
  assign o_ovr  = {if_b.overrun, if_a.overrun};

  function automatic logic [15:0] data_of(input int d);
    return (d == 0) ? {8'h00, if_a.data} : if_b.data;
  endfunction

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge cin);
    #1;
  endtask

  // Monitor: a new word is ordy rising, or data changing while ordy stays high.
  logic [1:0]  prev_ordy = 2'b00;
  logic [15:0] prev_data [2];

  task automatic mon_step(input int d);
    logic [15:0] dv;
    logic [15:0] ev;
    dv = data_of(d);
    if (!rst_n_drv[d]) begin
      prev_ordy[d] = 1'b0;
      prev_data[d] = dv;
    end else begin
      if (o_ordy[d] && (!prev_ordy[d] || dv !== prev_data[d])) begin
        if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word dut%0d: got %h expected none", d, dv);
        end else begin
          ev = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
          check($sformatf("sb_word_dut%0d", d), dv, ev);
        end
      end
      prev_ordy[d] = o_ordy[d];
      prev_data[d] = dv;
    end
  endtask

  always @(negedge cin) begin
    mon_step(0);
    mon_step(1);
  end

  // Reference: the expected word is the sent value itself, queued only when all WIDTH bits go out.
  // Each bit leaves scl idle, presents sda, then returns scl to idle (the sampling edge in both modes).
  task automatic send_word(input int d, input logic [15:0] val, input int nbits,
                           input int half, input bit ack_last, output int lat);
    int   w;
    logic idle;
    logic was;
    w    = (d == 0) ? 8 : 16;
    idle = (d == 0) ? 1'b0 : 1'b1;
    lat  = -1;
    if (nbits == w) begin
      if (d == 0) exp_a.push_back(val);
      else        exp_b.push_back(val);
    end
    for (int i = 0; i < nbits; i++) begin
      scl_drv[d] = ~idle;
      sda_drv[d] = val[w-1-i];
      wait_cyc(half);
      scl_drv[d] = idle;
      if (i == nbits - 1) begin
        was = o_ordy[d];
        for (int k = 1; k <= half; k++) begin
          wait_cyc(1);
          if (ack_last && k == 2) ack_drv[d] = 1'b1;
          if (ack_last && k == 3) ack_drv[d] = 1'b0;
          if (lat < 0 && !was && o_ordy[d]) lat = k;
        end
      end else begin
        wait_cyc(half);
      end
    end
  endtask

  task automatic wait_ordy(input int d, input string name);
    int n;
    n = 0;
    while (!o_ordy[d] && n < 40) begin
      wait_cyc(1);
      n++;
    end
    check(name, o_ordy[d], 1'b1);
  endtask

  task automatic do_ack(input int d);
    ack_drv[d] = 1'b1;
    wait_cyc(1);
    ack_drv[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst_n_drv[d] = 1'b0;
    scl_drv[d]   = (d == 0) ? 1'b0 : 1'b1;
    sda_drv[d]   = 1'b0;
    wait_cyc(3);
    rst_n_drv[d] = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] v;
    logic [15:0] prev_v;
    int          d;
    int          half;

    // T1: reset held while the pins toggle; outputs stay at their reset values.
    for (int c = 0; c < 3; c++) begin
      @(posedge cin);
      #1;
      scl_drv = 2'($urandom);
      sda_drv = 2'($urandom);
      @(negedge cin);
      check("t1_ordy", {14'd0, o_ordy}, 16'd0);
      check("t1_busy", {14'd0, o_busy}, 16'd0);
      check("t1_ovr",  {14'd0, o_ovr},  16'd0);
      check("t1_data_a", data_of(0), 16'd0);
      check("t1_data_b", data_of(1), 16'd0);
    end
    @(posedge cin);
    #1;
    scl_drv = 2'b10;
    sda_drv = 2'b00;
    wait_cyc(2);
    rst_n_drv = 2'b11;
    wait_cyc(3);
    check("t1_idle_after_release", {14'd0, o_busy}, 16'd0);

    // T2: one word, latency of ordy, ack clears ordy and leaves data.
    send_word(0, 16'h00A5, 8, 4, 1'b0, lat);
    check("t2_latency_ok", 16'((lat >= 1) && (lat <= SYNC + 2)), 16'd1);
    check("t2_data", data_of(0), 16'h00A5);
    do_ack(0);
    check("t2_ordy_after_ack", o_ordy[0], 1'b0);
    check("t2_data_held", data_of(0), 16'h00A5);
    check("t2_ovr", o_ovr[0], 1'b0);

    // T3: unread word is overwritten and overrun sticks through the ack.
    send_word(0, 16'h003C, 8, 4, 1'b0, lat);
    check("t3_ordy_first", o_ordy[0], 1'b1);
    check("t3_ovr_first", o_ovr[0], 1'b0);
    send_word(0, 16'h00C3, 8, 4, 1'b0, lat);
    check("t3_data", data_of(0), 16'h00C3);
    check("t3_ordy", o_ordy[0], 1'b1);
    check("t3_ovr_set", o_ovr[0], 1'b1);
    do_ack(0);
    check("t3_ordy_after_ack", o_ordy[0], 1'b0);
    check("t3_ovr_sticky", o_ovr[0], 1'b1);

    // T4: three bits then a long stall; the partial word is dropped and the next word arrives intact.
    send_word(0, 16'h00FF, 3, 4, 1'b0, lat);
    check("t4_busy_mid", o_busy[0], 1'b1);
    wait_cyc(46);
    check("t4_busy_before_timeout", o_busy[0], 1'b1);
    wait_cyc(25);
    check("t4_busy_after_timeout", o_busy[0], 1'b0);
    check("t4_no_ordy", o_ordy[0], 1'b0);
    wait_cyc(5);
    send_word(0, 16'h0081, 8, 4, 1'b0, lat);
    wait_ordy(0, "t4_ordy");
    check("t4_data", data_of(0), 16'h0081);
    do_ack(0);

    // T5: ack on the exact completion edge of the second word.
    do_reset(0);
    check("t5_ovr_cleared", o_ovr[0], 1'b0);
    send_word(0, 16'h005A, 8, 4, 1'b0, lat);
    check("t5_ordy_first", o_ordy[0], 1'b1);
    send_word(0, 16'h0096, 8, 4, 1'b1, lat);
    check("t5_ordy", o_ordy[0], 1'b1);
    check("t5_data", data_of(0), 16'h0096);
    check("t5_ovr", o_ovr[0], 1'b0);
    wait_cyc(2);
    check("t5_ordy_held", o_ordy[0], 1'b1);
    do_ack(0);
    check("t5_ordy_after_ack", o_ordy[0], 1'b0);

    // T6: SCL_MODE=0, WIDTH=16; reset mid-word discards it, the resend arrives once.
    send_word(1, 16'hBEEF, 9, 4, 1'b0, lat);
    check("t6_busy_mid", o_busy[1], 1'b1);
    do_reset(1);
    wait_cyc(10);
    check("t6_no_ordy", o_ordy[1], 1'b0);
    check("t6_no_busy", o_busy[1], 1'b0);
    send_word(1, 16'hBEEF, 16, 4, 1'b0, lat);
    wait_ordy(1, "t6_ordy");
    check("t6_data", data_of(1), 16'hBEEF);
    do_ack(1);
    check("t6_ordy_after_ack", o_ordy[1], 1'b0);

    // Randomised words on both DUTs with varied scl rates.
    prev_v = 16'h0000;
    for (int r = 0; r < 10; r++) begin
      d    = r % 2;
      v    = 16'($urandom);
      if (d == 0) v = {8'h00, v[7:0]};
      half = int'($urandom_range(4, 6));
      send_word(d, v, (d == 0) ? 8 : 16, half, 1'b0, lat);
      wait_ordy(d, "rnd_ordy");
      check("rnd_data", data_of(d), v);
      do_ack(d);
      check("rnd_ordy_after_ack", o_ordy[d], 1'b0);
      prev_v = v;
    end

    wait_cyc(5);
    check("sb_empty_a", 16'(exp_a.size()), 16'd0);
    check("sb_empty_b", 16'(exp_b.size()), 16'd0);
    check("final_ovr_a", o_ovr[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
